pc_fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 15 +
 rtl/pc_fetch_sequencer_pc.sv | 24 ++
 rtl/pc_fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pc_fetch_sequencer_pc.sv
// Architectural PC register: loads i_pc_in when i_en, otherwise holds.
module pc_fetch_sequencer_pc #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [31:0] i_pc_in,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else if (i_en) begin
      r_pc <= i_pc_in;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC sequencing and one-request-per-instruction fetch handshake for the microcoded RV32 core.
// Define MISALIGN_TRAP_EN to trap misaligned redirect targets and expose misalign_exc.
module pc_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          MAX_WAIT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        retire,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  output logic        fetch_timeout,
  output logic [31:0] pc_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_exc
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  fetch_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [31:0]   r_instr, r_instr_pc, w_pc_nxt;
  logic          r_timeout, w_timeout_set, w_capture, w_pc_en;
`ifdef MISALIGN_TRAP_EN
  logic          r_misalign_exc, w_misalign;
`endif

  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_capture     = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      FETCH: begin
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ISSUE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CW'(MAX_WAIT)) begin
            w_timeout_set = 1'b1;
            w_state_nxt   = HALT;
          end
        end
      end
      ISSUE:   if (instr_ready) w_state_nxt = EXEC;
      EXEC:    if (retire) w_state_nxt = FETCH;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  // Next-PC priority: trap, then redirect, then sequential.
  always_comb begin
    w_pc_nxt = pc_out + PC_STEP;
`ifdef MISALIGN_TRAP_EN
    w_misalign = 1'b0;
`endif
    if (trap_valid) begin
      w_pc_nxt = TRAP_VECTOR;
    end else if (redirect_valid) begin
`ifdef MISALIGN_TRAP_EN
      if (redirect_target[1:0] != 2'b00) begin
        w_pc_nxt   = TRAP_VECTOR;
        w_misalign = 1'b1;
      end else begin
        w_pc_nxt = redirect_target;
      end
`else
      w_pc_nxt = redirect_target & 32'hFFFF_FFFC;
`endif
    end
  end

  assign w_pc_en = (r_state == EXEC) && retire;

  pc_fetch_sequencer_pc #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_pc_en),
    .i_pc_in(w_pc_nxt),
    .o_pc   (pc_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_cnt      <= '0;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= RESET_VECTOR;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= pc_out;
      end
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign_exc <= 1'b0;
    else     r_misalign_exc <= w_pc_en && w_misalign;
  end
  assign misalign_exc = r_misalign_exc;
`endif

  // Gated by rst so an in-flight request is abandoned the moment reset asserts.
  assign imem_req      = !rst && ((r_state == FETCH) || (r_state == WAIT));
  assign imem_addr     = pc_out;
  assign instr_valid   = (r_state == ISSUE);
  assign instr         = r_instr;
  assign instr_pc      = r_instr_pc;
  assign fetch_timeout = r_timeout;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer (MAX_WAIT = 4); honours MISALIGN_TRAP_EN.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack, instr_valid, instr_ready, retire;
  logic        redirect_valid, trap_valid, fetch_timeout;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_target, pc_out;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] model_pc;
  logic [31:0] last_instr;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pc_fetch_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100),
    .MAX_WAIT    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .retire         (retire),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid     (trap_valid),
    .fetch_timeout  (fetch_timeout),
    .pc_out         (pc_out)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_exc   (misalign_exc)
`endif
  );

  function automatic logic [31:0] next_pc(logic [31:0] pc, bit trap, bit redir, logic [31:0] tgt);
    if (trap) return 32'h0000_0100;
    if (redir) begin
`ifdef MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) return 32'h0000_0100;
      return tgt;
`else
      return {tgt[31:2], 2'b00};
`endif
    end
    return pc + 32'd4;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic serve(input int dly, input logic [31:0] rdata, output logic [31:0] addr, output bit ok);
    wait_req(ok);
    addr = imem_addr;
    if (!ok) return;
    repeat (dly) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    last_instr = rdata;
  endtask

  task automatic accept(input int n);
    instr_ready = 1'b0;
    repeat (n) @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic do_retire(input bit trap, input bit redir, input logic [31:0] tgt);
    retire = 1'b1;
    trap_valid = trap;
    redirect_valid = redir;
    redirect_target = tgt;
    @(negedge clk);
    retire = 1'b0;
    trap_valid = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    model_pc = next_pc(model_pc, trap, redir, tgt);
  endtask

  task automatic run_instr(input string tag, input int dly, input logic [31:0] rdata, input int rdy,
                           input bit trap, input bit redir, input logic [31:0] tgt);
    logic [31:0] addr, e;
    bit ok;
    exp_q.push_back(model_pc);
    exp_q.push_back(rdata);
    exp_q.push_back(model_pc);
    serve(dly, rdata, addr, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_req_timeout: imem_req=%b want 1", tag, imem_req); end
    e = exp_q.pop_front();
    checks++; if (addr !== e) begin failures++; $display("FAIL %s_addr: got %h want %h", tag, addr, e); end
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL %s_valid: got %b want 1", tag, instr_valid); end
    e = exp_q.pop_front();
    checks++; if (instr !== e) begin failures++; $display("FAIL %s_instr: got %h want %h", tag, instr, e); end
    e = exp_q.pop_front();
    checks++; if (instr_pc !== e) begin failures++; $display("FAIL %s_instr_pc: got %h want %h", tag, instr_pc, e); end
    accept(rdy);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL %s_exec_valid: got %b want 0", tag, instr_valid); end
    do_retire(trap, redir, tgt);
    checks++; if (pc_out !== model_pc) begin failures++; $display("FAIL %s_pc: got %h want %h", tag, pc_out, model_pc); end
  endtask

  task automatic test_reset();
    imem_ack = 0; imem_rdata = 0; instr_ready = 0; retire = 0;
    redirect_valid = 0; redirect_target = 0; trap_valid = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", pc_out); end
    checks++; if (instr !== 32'h13) begin failures++; $display("FAIL rst_instr: got %h want 00000013", instr); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    checks++; if (fetch_timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout: got %b want 0", fetch_timeout); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rel_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rel_addr: got %h want 0", imem_addr); end
    model_pc = 32'h0;
  endtask

  task automatic test_first_fetch();
    run_instr("first", 1, 32'h0050_0093, 0, 0, 0, 32'h0);
    checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL first_pc4: got %h want 4", pc_out); end
  endtask

  task automatic test_redirect();
    run_instr("jump", 0, 32'h0000_006F, 0, 0, 1, 32'h0000_0040);
    run_instr("trap", 0, 32'h0000_0073, 1, 1, 1, 32'h0000_0080);
    checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL trap_vec: got %h want 00000100", pc_out); end
  endtask

  task automatic test_stall_issue();
    logic [31:0] addr;
    bit ok;
    serve(2, 32'h1234_5678, addr, ok);
    checks++; if (addr !== model_pc || !ok) begin failures++; $display("FAIL stall_addr: got %h want %h", addr, model_pc); end
    for (int i = 0; i < 5; i++) begin
      instr_ready = 1'b0;
      retire = (i == 2);
      @(negedge clk);
      retire = 1'b0;
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
      checks++; if (instr !== 32'h1234_5678) begin failures++; $display("FAIL stall_instr[%0d]: got %h want 12345678", i, instr); end
      checks++; if (pc_out !== model_pc) begin failures++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc_out, model_pc); end
    end
    accept(0);
    do_retire(0, 0, 32'h0);
    checks++; if (pc_out !== 32'h104) begin failures++; $display("FAIL stall_seq: got %h want 00000104", pc_out); end
  endtask

  task automatic test_wrap();
    run_instr("to_top", 0, 32'h0000_006F, 0, 0, 1, 32'hFFFF_FFFC);
    run_instr("wrap", 1, 32'h0000_0013, 0, 0, 0, 32'h0);
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h want 0", pc_out); end
  endtask

  task automatic test_ignored();
    logic [31:0] addr;
    logic [31:0] pc_before;
    bit ok;
    serve(0, 32'h1111_1111, addr, ok);
    accept(0);
    pc_before = pc_out;
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0; trap_valid = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    checks++; if (instr !== 32'h1111_1111) begin failures++; $display("FAIL ign_instr: got %h want 11111111", instr); end
    checks++; if (pc_out !== pc_before) begin failures++; $display("FAIL ign_pc: got %h want %h", pc_out, pc_before); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ign_req: got %b want 0", imem_req); end
    do_retire(0, 0, 32'h0);
    checks++; if (pc_out !== model_pc) begin failures++; $display("FAIL ign_seq: got %h want %h", pc_out, model_pc); end
  endtask

  task automatic test_misalign();
    logic [31:0] addr;
    bit ok;
    serve(0, 32'h0000_006F, addr, ok);
    accept(0);
    do_retire(0, 1, 32'h0000_0042);
`ifdef MISALIGN_TRAP_EN
    checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL mis_pc: got %h want 00000100", pc_out); end
    checks++; if (misalign_exc !== 1'b1) begin failures++; $display("FAIL mis_exc_hi: got %b want 1", misalign_exc); end
    @(negedge clk);
    checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL mis_exc_lo: got %b want 0", misalign_exc); end
`else
    checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL mis_pc: got %h want 00000040", pc_out); end
`endif
  endtask

  task automatic test_rst_in_wait();
    bit ok;
    wait_req(ok);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstw_req: got %b want 0", imem_req); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rstw_pc: got %h want 0", pc_out); end
    @(negedge clk);
    rst = 1'b0;
    model_pc = 32'h0;
    run_instr("after_rst", 0, 32'h00A0_0113, 0, 0, 0, 32'h0);
  endtask

  task automatic test_timeout();
    logic [31:0] pc_before;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b1 || fetch_timeout !== 1'b0) begin failures++; $display("FAIL to_early: req=%b to=%b want 1/0", imem_req, fetch_timeout); end
    repeat (3) @(negedge clk);
    checks++; if (fetch_timeout !== 1'b1) begin failures++; $display("FAIL to_flag: got %b want 1", fetch_timeout); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL to_req: got %b want 0", imem_req); end
    pc_before = pc_out;
    imem_ack = 1'b1; imem_rdata = 32'h3333_3333; retire = 1'b1; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0; retire = 1'b0; instr_ready = 1'b0;
    checks++; if (instr !== last_instr) begin failures++; $display("FAIL halt_instr: got %h want %h", instr, last_instr); end
    checks++; if (pc_out !== pc_before) begin failures++; $display("FAIL halt_pc: got %h want %h", pc_out, pc_before); end
    checks++; if (fetch_timeout !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL halt_hold: to=%b req=%b vld=%b want 1/0/0", fetch_timeout, imem_req, instr_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (fetch_timeout !== 1'b0) begin failures++; $display("FAIL to_clear: got %b want 0", fetch_timeout); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL to_restart: got %b want 1", imem_req); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_redirect();
    test_stall_issue();
    test_wrap();
    test_ignored();
    test_misalign();
    test_rst_in_wait();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
